// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared types and constants for the cal_start sequencer
//
// Contents:
//   cal_state_t          sequencer state encoding (IDLE, RUN, DONE)
//   CAL_ITER_W_DEF       default pass-count width
//   CAL_TIMEOUT_CYC_DEF  default ack-wait limit in cycles
//   CAL_STS_*            bit positions inside the future cal_status register
package cal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cal_state_t;

    localparam int CAL_ITER_W_DEF      = 8;
    localparam int CAL_TIMEOUT_CYC_DEF = 1024;

    localparam int CAL_STS_BUSY  = 0;
    localparam int CAL_STS_ABORT = 1;
    localparam int CAL_STS_OVR   = 2;
    localparam int CAL_STS_TMO   = 3;

endpackage

// File: rtl/cal_start_wdog.sv
// rtl/cal_start_wdog.sv - ack-wait watchdog for the cal_start sequencer
//
// Built only when CAL_START_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   run         sequencer is in RUN
//   ack         datapath acknowledged a pass this cycle
//   expire      RUN has gone TIMEOUT_CYC cycles without an ack (this cycle included)
module cal_start_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic ack,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside RUN, so it is already clear on the first RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!run || ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expire = run && !ack && (wait_cnt == LIMIT);

endmodule

// File: rtl/cal_start_ctrl.sv
// rtl/cal_start_ctrl.sv - sequencer behind the cal_start register field
//
// A write of 1 to start_en launches iter_num passes of the calculation
// datapath over cal_req/cal_ack, then self-clears the start field.
// Optional macro CAL_START_TIMEOUT_EN adds an ack-wait timeout (cal_start_wdog).
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   start_en, start_wr    start field value and its write strobe
//   iter_num              pass count, sampled at launch
//   cal_req, cal_ack      pass handshake; cal_first / cal_last qualify cal_req
//   pass_cnt              passes acknowledged in the current or last run
//   busy, done_pulse      run status
//   abort_flag, ovr_flag, tmo_flag   sticky status of the last run
//   start_clr_en, start_clr          start field hardware-update path
module cal_start_ctrl
    import cal_pkg::*;
#(
    parameter int ITER_W      = CAL_ITER_W_DEF,
    parameter int TIMEOUT_CYC = CAL_TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_en,
    input  logic              start_wr,
    input  logic [ITER_W-1:0] iter_num,
    output logic              cal_req,
    input  logic              cal_ack,
    output logic              cal_first,
    output logic              cal_last,
    output logic [ITER_W-1:0] pass_cnt,
    output logic              busy,
    output logic              done_pulse,
    output logic              abort_flag,
    output logic              ovr_flag,
    output logic              tmo_flag,
    output logic              start_clr_en,
    output logic              start_clr
);

    localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

    cal_state_t        state, state_next;
    logic [ITER_W-1:0] iter_lat;
    logic              launch_ev, abort_ev, ack_hit, last_pass, tmo_hit;
    logic              do_launch, set_abort, set_ovr, set_tmo;

    assign launch_ev = start_wr && start_en;
    assign abort_ev  = start_wr && !start_en;
    assign ack_hit   = (state == RUN) && cal_ack;
    assign last_pass = (pass_cnt == iter_lat - ONE);
    assign start_clr = 1'b0;

    always_comb begin
        state_next   = state;
        do_launch    = 1'b0;
        set_abort    = 1'b0;
        set_ovr      = 1'b0;
        set_tmo      = 1'b0;
        cal_req      = 1'b0;
        cal_first    = 1'b0;
        cal_last     = 1'b0;
        busy         = 1'b0;
        done_pulse   = 1'b0;
        start_clr_en = 1'b0;
        case (state)
            IDLE: begin
                if (launch_ev) begin
                    do_launch  = 1'b1;
                    state_next = (iter_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                cal_req   = 1'b1;
                busy      = 1'b1;
                cal_first = (pass_cnt == '0);
                cal_last  = last_pass;
                set_ovr   = launch_ev;
                // A final ack wins over a coincident abort or timeout.
                if (ack_hit && last_pass) begin
                    state_next = DONE;
                end else if (abort_ev || tmo_hit) begin
                    state_next = DONE;
                    set_abort  = abort_ev;
                    set_tmo    = tmo_hit;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done_pulse   = 1'b1;
                start_clr_en = 1'b1;
                set_ovr      = start_wr;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            iter_lat   <= '0;
            pass_cnt   <= '0;
            abort_flag <= 1'b0;
            ovr_flag   <= 1'b0;
        end else begin
            state <= state_next;
            if (do_launch) begin
                iter_lat   <= iter_num;
                pass_cnt   <= '0;
                abort_flag <= 1'b0;
                ovr_flag   <= 1'b0;
            end else begin
                if (ack_hit)   pass_cnt   <= pass_cnt + ONE;
                if (set_abort) abort_flag <= 1'b1;
                if (set_ovr)   ovr_flag   <= 1'b1;
            end
        end
    end

`ifdef CAL_START_TIMEOUT_EN
    logic tmo_q;

    cal_start_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == RUN),
        .ack   (cal_ack),
        .expire(tmo_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else if (do_launch) begin
            tmo_q <= 1'b0;
        end else if (set_tmo) begin
            tmo_q <= 1'b1;
        end
    end

    assign tmo_flag = tmo_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign tmo_flag   = 1'b0;
    assign unused_tmo = set_tmo ^ (TIMEOUT_CYC > 1);
`endif

endmodule

// File: tb/tb_cal_start_ctrl.sv
// tb/tb_cal_start_ctrl.sv - self-checking bench for cal_start_ctrl
module tb_cal_start_ctrl;

    localparam int TMO = 16;
`ifdef CAL_START_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_en = 1'b0;
    logic       start_wr = 1'b0;
    logic [7:0] iter_num = '0;
    logic       cal_req, cal_ack = 1'b0, cal_first, cal_last;
    logic [7:0] pass_cnt;
    logic       busy, done_pulse, abort_flag, ovr_flag, tmo_flag;
    logic       start_clr_en, start_clr;

    int total = 0;
    int bad = 0;

    cal_start_ctrl #(.ITER_W(8), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_en(start_en), .start_wr(start_wr),
        .iter_num(iter_num), .cal_req(cal_req), .cal_ack(cal_ack),
        .cal_first(cal_first), .cal_last(cal_last), .pass_cnt(pass_cnt),
        .busy(busy), .done_pulse(done_pulse), .abort_flag(abort_flag),
        .ovr_flag(ovr_flag), .tmo_flag(tmo_flag),
        .start_clr_en(start_clr_en), .start_clr(start_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete run: launch, RUN cycles with random acks, DONE, then idle.
    // The model counts passes and consecutive ack-less cycles and decides the
    // outcome from the rules directly: last ack wins, else abort/timeout end it.
    task automatic do_run(input int n, input int prob, input int abort_at,
                          input int ovr_at, input bit done_evt);
        int  p = 0;
        int  quiet = 0;
        int  k = 0;
        bit  ab = 0, tm = 0, ov = 0, fin = 0, hit_ab, hit_ov;
        @(negedge clk);
        start_en = 1'b1; start_wr = 1'b1; iter_num = 8'(n); cal_ack = 1'($urandom);
        #1;
        chk("launch_req", cal_req, 0);
        chk("launch_busy", busy, 0);
        if (n > 0) begin
            while (!fin) begin
                @(negedge clk);
                start_wr = 1'b0;
                hit_ab = 0; hit_ov = 0;
                cal_ack = (int'($urandom_range(0, 99)) < prob);
                if (k == abort_at) begin
                    start_en = 1'b0; start_wr = 1'b1; hit_ab = 1;
                end else if (k == ovr_at) begin
                    start_en = 1'b1; start_wr = 1'b1; hit_ov = 1;
                end
                #1;
                chk("run_req", cal_req, 1);
                chk("run_busy", busy, 1);
                chk("run_first", cal_first, (p == 0));
                chk("run_last", cal_last, (p == n - 1));
                chk("run_cnt", pass_cnt, p);
                chk("run_done", done_pulse, 0);
                if (hit_ov) ov = 1;
                if (cal_ack) begin p++; quiet = 0; end else quiet++;
                if (p == n) fin = 1;
                else begin
                    if (hit_ab) begin ab = 1; fin = 1; end
                    if (TMO_ON && quiet == TMO) begin tm = 1; fin = 1; end
                end
                k++;
                if (k > 3000) begin
                    chk("run_bound", k, 0);
                    fin = 1;
                end
            end
        end
        @(negedge clk);
        start_wr = 1'b0; cal_ack = 1'($urandom);
        if (done_evt) begin
            start_wr = 1'b1; start_en = 1'($urandom); ov = 1;
        end
        #1;
        chk("done_pulse", done_pulse, 1);
        chk("done_clr_en", start_clr_en, 1);
        chk("done_clr", start_clr, 0);
        chk("done_busy", busy, 1);
        chk("done_req", cal_req, 0);
        chk("done_cnt", pass_cnt, p);
        @(negedge clk);
        start_wr = 1'b0; cal_ack = 1'b0;
        #1;
        chk("idle_done", done_pulse, 0);
        chk("idle_busy", busy, 0);
        chk("idle_req", cal_req, 0);
        chk("idle_clr_en", start_clr_en, 0);
        chk("idle_cnt", pass_cnt, p);
        chk("idle_abort", abort_flag, ab);
        chk("idle_ovr", ovr_flag, ov);
        chk("idle_tmo", tmo_flag, tm);
    endtask

    initial begin
        int n, prob, ab_at, ov_at;
        #1;
        chk("rst_req", cal_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_cnt", pass_cnt, 0);
        chk("rst_flags", {abort_flag, ovr_flag, tmo_flag, start_clr_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run(3, 100, -1, -1, 1'b0);
        do_run(0, 100, -1, -1, 1'b0);
        do_run(4, 100, 2, -1, 1'b0);
        do_run(1, 100, 0, -1, 1'b0);
        do_run(5, 100, -1, 2, 1'b0);
        do_run(2, 100, -1, -1, 1'b0);
        do_run(3, 60, -1, -1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            n     = $urandom_range(0, 6);
            prob  = $urandom_range(30, 100);
            ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
            ov_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
            do_run(n, prob, ab_at, ov_at, 1'($urandom));
        end

        // No acks: times out after TMO cycles when built with the timeout,
        // otherwise waits until the abort at cycle 40.
        do_run(3, 0, 40, -1, 1'b0);
        do_run(2, 0, TMO - 1, -1, 1'b0);

        // Reset in the middle of a run with ovr_flag set.
        @(negedge clk);
        start_en = 1'b1; start_wr = 1'b1; iter_num = 8'd5; cal_ack = 1'b0;
        @(negedge clk);
        start_wr = 1'b1; cal_ack = 1'b1;
        @(negedge clk);
        start_wr = 1'b0; cal_ack = 1'b0;
        #1;
        chk("mid_ovr", ovr_flag, 1);
        chk("mid_cnt", pass_cnt, 1);
        chk("mid_req", cal_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", cal_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", pass_cnt, 0);
        chk("arst_flags", {abort_flag, ovr_flag, tmo_flag, done_pulse}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run(2, 100, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
